// File: rtl/interp_sample_ctrl_pkg.sv
// Shared definitions for the interpolation sample-count datapath:
// FSM encoding, index width and default block geometry.
package interp_sample_ctrl_pkg;

  localparam int CNT_W           = 4;
  localparam int DEF_NUM_SAMPLES = 16;
  localparam int DEF_PIPE_LAT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/interp_sample_ctrl_add_count.sv
// Existing 4-bit count adder; the carry is dropped, so the sum wraps modulo 2^CNT_W.
module add_count_block
  import interp_sample_ctrl_pkg::*;
(
  input  logic [CNT_W-1:0] A,
  input  logic [CNT_W-1:0] B,
  output logic [CNT_W-1:0] C
);

  assign C = A + B;

endmodule

// File: rtl/interp_sample_ctrl.sv
// Walks one block of sample indices with a latched stride, flags the last beat,
// drains the downstream pipeline and pulses done.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start_i; latches the stride
//   ST_RUN   | issuing one index per unstalled cycle
//   ST_DRAIN | waiting PIPE_LAT cycles for the datapath to empty
//   ST_DONE  | one-cycle completion pulse
module interp_sample_ctrl
  import interp_sample_ctrl_pkg::*;
#(
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] step_i,
  input  logic             stall_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] sample_idx_o,
  output logic             sample_vld_o,
  output logic             last_o,
  output logic             done_o
);

  // One extra bit so NUM_SAMPLES = 2^CNT_W is representable in the compare.
  localparam logic [CNT_W:0]   NS_LIM     = (CNT_W + 1)'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(PIPE_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_step;
  logic [CNT_W-1:0] r_drain;

  logic [CNT_W-1:0] w_sum;
  logic             w_wrap;
  logic             w_term;
  logic             w_vld;

  add_count_block u_add (
    .A (r_idx),
    .B (r_step),
    .C (w_sum)
  );

  assign w_wrap = (w_sum < r_idx);
  assign w_term = w_wrap | ({1'b0, w_sum} >= NS_LIM);
  assign w_vld  = (r_state == ST_RUN) & ~stall_i;

  assign sample_vld_o = w_vld;
  assign sample_idx_o = r_idx;
  assign last_o       = w_vld & w_term;
  assign busy_o       = (r_state != ST_IDLE);
  assign done_o       = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_step  <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_step  <= (step_i == '0) ? CNT_W'(1) : step_i;
          end
        end
        ST_RUN: begin
          if (!stall_i) begin
            if (w_term) begin
              r_state <= ST_DRAIN;
              r_drain <= DRAIN_INIT;
            end else begin
              r_idx <= w_sum;
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_sample_ctrl.sv
// Directed bench for interp_sample_ctrl: three instances (16, 10 and 1 samples per block)
// share stimulus; one is selected for observation per scenario.
module tb_interp_sample_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       stall_i;
  logic [3:0] step_i;

  logic       busy0, vld0, last0, done0;
  logic [3:0] idx0;
  logic       busy1, vld1, last1, done1;
  logic [3:0] idx1;
  logic       busy2, vld2, last2, done2;
  logic [3:0] idx2;

  logic [1:0] sel;
  logic       busy_m, vld_m, last_m, done_m;
  logic [3:0] idx_m;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  int idle_cyc;
  int b_idx[$];
  int b_last[$];
  int b_cyc[$];
  int d_cyc[$];

  always #5 clk = ~clk;

  interp_sample_ctrl #(.NUM_SAMPLES(16), .PIPE_LAT(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .step_i(step_i), .stall_i(stall_i),
    .busy_o(busy0), .sample_idx_o(idx0), .sample_vld_o(vld0), .last_o(last0), .done_o(done0)
  );

  interp_sample_ctrl #(.NUM_SAMPLES(10), .PIPE_LAT(2)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .step_i(step_i), .stall_i(stall_i),
    .busy_o(busy1), .sample_idx_o(idx1), .sample_vld_o(vld1), .last_o(last1), .done_o(done1)
  );

  interp_sample_ctrl #(.NUM_SAMPLES(1), .PIPE_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .step_i(step_i), .stall_i(stall_i),
    .busy_o(busy2), .sample_idx_o(idx2), .sample_vld_o(vld2), .last_o(last2), .done_o(done2)
  );

  always_comb begin
    busy_m = busy0; vld_m = vld0; last_m = last0; done_m = done0; idx_m = idx0;
    case (sel)
      2'd1: begin busy_m = busy1; vld_m = vld1; last_m = last1; done_m = done1; idx_m = idx1; end
      2'd2: begin busy_m = busy2; vld_m = vld2; last_m = last2; done_m = done2; idx_m = idx2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Inputs for a cycle are chosen from registered outputs right after the edge,
  // then combinational outputs are sampled 1 time unit later.
  task automatic run_block(input logic [3:0] step, input int stall_at, input int stall_len,
                           input int restart_at, input int rst_at);
    int stalls;
    bit rst_pend;
    b_idx.delete(); b_last.delete(); b_cyc.delete(); d_cyc.delete();
    idle_cyc = -1;
    cyc      = 0;
    stalls   = 0;
    rst_pend = 1'b0;
    start_i  = 1'b1;
    step_i   = step;
    stall_i  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      start_i = 1'b0;
      stall_i = 1'b0;
      rst_n   = 1'b1;
      if (busy_m && int'(idx_m) == stall_at && stalls < stall_len) begin
        stall_i = 1'b1;
        stalls++;
      end
      if (busy_m && int'(idx_m) == restart_at) start_i = 1'b1;
      if (busy_m && int'(idx_m) == rst_at) rst_n = 1'b0;
      #1;
      if (rst_pend) begin
        check("rst_outputs_zero", {busy_m, vld_m, last_m, done_m, idx_m}, 32'd0);
        rst_pend = 1'b0;
      end
      if (!rst_n) rst_pend = 1'b1;
      if (vld_m) begin
        b_idx.push_back(int'(idx_m));
        b_last.push_back(int'(last_m));
        b_cyc.push_back(cyc);
      end
      if (done_m) d_cyc.push_back(cyc);
      if (!busy_m && d_cyc.size() > 0) begin
        idle_cyc = cyc;
        break;
      end
      if (rst_at >= 0 && cyc >= 35) break;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic drain_all();
    for (int k = 0; k < 60; k++) begin
      if (!(busy0 | busy1 | busy2)) break;
      tick();
    end
    check("all_idle", {31'd0, busy0 | busy1 | busy2}, 32'd0);
  endtask

  // Beat indices must match exp exactly, with last_o only on the final beat.
  task automatic check_seq(input string tag, input int exp[$]);
    check({tag, "_beats"}, b_idx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < b_idx.size(); i++) begin
      check({tag, "_idx"}, b_idx[i], exp[i]);
      check({tag, "_last"}, b_last[i], (i == exp.size() - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int e[$];
    rst_n   = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    step_i  = 4'd0;
    sel     = 2'd0;
    cyc     = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("reset_outputs", {busy_m, vld_m, last_m, done_m, idx_m}, 32'd0);
    tick();

    e.delete();
    for (int i = 0; i < 16; i++) e.push_back(i);

    run_block(4'd1, -1, 0, -1, -1);
    check_seq("step1", e);
    check("step1_first_cyc", b_cyc[0], 1);
    check("step1_last_cyc", b_cyc[15], 16);
    check("step1_done_cnt", d_cyc.size(), 1);
    check("step1_done_cyc", d_cyc[0], 19);
    check("step1_idle_cyc", idle_cyc, 20);
    drain_all();

    run_block(4'd4, -1, 0, -1, -1);
    check_seq("step4", '{0, 4, 8, 12});
    check("step4_done_cyc", d_cyc[0], 7);
    drain_all();

    run_block(4'd3, -1, 0, -1, -1);
    check_seq("step3", '{0, 3, 6, 9, 12, 15});
    check("step3_done_cyc", d_cyc[0], 9);
    drain_all();

    run_block(4'd1, 5, 3, -1, -1);
    check_seq("stall", e);
    check("stall_idx4_cyc", b_cyc[4], 5);
    check("stall_idx5_cyc", b_cyc[5], 9);
    check("stall_done_cnt", d_cyc.size(), 1);
    check("stall_done_cyc", d_cyc[0], 22);
    drain_all();

    run_block(4'd1, -1, 0, 7, -1);
    check_seq("restart", e);
    check("restart_done_cnt", d_cyc.size(), 1);
    check("restart_done_cyc", d_cyc[0], 19);
    drain_all();

    run_block(4'd0, -1, 0, -1, -1);
    check_seq("step0", e);
    check("step0_done_cyc", d_cyc[0], 19);
    drain_all();

    run_block(4'd1, -1, 0, -1, 9);
    check("rst_beats", b_idx.size(), 10);
    check("rst_no_done", d_cyc.size(), 0);
    drain_all();
    run_block(4'd1, -1, 0, -1, -1);
    check_seq("after_rst", e);
    check("after_rst_done_cyc", d_cyc[0], 19);
    drain_all();

    sel = 2'd1;
    run_block(4'd3, -1, 0, -1, -1);
    check_seq("ns10_step3", '{0, 3, 6, 9});
    check("ns10_done_cyc", d_cyc[0], 7);
    drain_all();

    sel = 2'd2;
    run_block(4'd1, -1, 0, -1, -1);
    check_seq("ns1", '{0});
    check("ns1_done_cyc", d_cyc[0], 4);
    check("ns1_idle_cyc", idle_cyc, 5);
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
